drum_cmd_spi_queue: RTL and testbench

Multi-channel drum-command queue and MCU SPI transmitter. Collects single-cycle trigger pulses from up to NUM_CH drum detectors and arbitrates simultaneous hits. Buffers the resulting command codes in a DEPTH-entry FIFO and serialises them MSB-first to the MCU using the DONE/LOAD handshake. It sits between the trigger-detection logic and the MCU SPI pins, and replaces the single-command, single-channel path.

---
 rtl/drum_cmd_spi_queue.sv | 184 ++++++++++++++++++
 tb/tb_drum_cmd_spi_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_cmd_spi_queue.sv
// drum_cmd_spi_queue
//   Collects single-cycle drum hit pulses into a pending register. A
//   lowest-index-first arbiter moves one hit per cycle into a DEPTH-entry
//   FIFO. The FIFO head is shifted out MSB-first to the MCU using the
//   DONE/LOAD handshake. Channel i is sent as command code i+1; code 0
//   means "no event".
//
// Ports
//   clk         system clock (at least 4x mcu_sck)
//   fpga_rst_n  asynchronous active-low reset
//   trig        per-channel hit pulses, clk-synchronous
//   mcu_sck     MCU SPI clock (asynchronous); sdo advances on its falling edge
//   mcu_load    MCU acknowledge (asynchronous); its rising edge pops the command
//   mcu_sdo     serial command bit, 0 whenever mcu_done is low
//   mcu_done    high while a command is presented
//   fifo_count  occupied FIFO entries
//   overflow    sticky flag, set when a hit merges into an already pending one
//   ovf_clr     synchronous clear of overflow (a same-cycle merge wins)
module drum_cmd_spi_queue #(
  parameter int NUM_CH = 8,
  parameter int CMD_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       fpga_rst_n,
  input  logic [NUM_CH-1:0]          trig,
  input  logic                       mcu_sck,
  input  logic                       mcu_load,
  output logic                       mcu_sdo,
  output logic                       mcu_done,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(CMD_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_LOAD} state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   pend;
  logic [NUM_CH-1:0]   arb_hit;
  logic [NUM_CH-1:0]   clr_mask;
  logic [CMD_W-1:0]    arb_code;
  logic [CMD_W-1:0]    mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CMD_W-1:0]    shreg;
  logic [BW-1:0]       bcnt;
  logic                sck_s1, sck_s2, sck_d;
  logic                load_s1, load_s2, load_d;
  logic                sck_fall, load_rise;
  logic                fifo_full, push, pop, merge;
  logic                load_sh, shift_en;

  assign sck_fall  = sck_d & ~sck_s2;
  assign load_rise = load_s2 & ~load_d;
  assign fifo_full = (fifo_count == (AW+1)'(DEPTH));

  // Arbiter: the lowest pending index wins; the loop runs high-to-low so the
  // last match is the lowest index.
  always_comb begin
    arb_code = '0;
    arb_hit  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        arb_code   = CMD_W'(i + 1);
        arb_hit    = '0;
        arb_hit[i] = 1'b1;
      end
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write.
  assign push     = (|pend) & (~fifo_full | pop);
  assign clr_mask = push ? arb_hit : '0;
  // A trig that lands on a bit being cleared this cycle re-arms it and is not a merge.
  assign merge    = |(trig & pend & ~clr_mask);

  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      pend <= (pend & ~clr_mask) | trig;
      if (merge)        overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= arb_code;
  end

  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Two-flop synchronisers, then one delay flop for edge detection.
  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_d   <= 1'b0;
      load_s1 <= 1'b0;
      load_s2 <= 1'b0;
      load_d  <= 1'b0;
    end else begin
      sck_s1  <= mcu_sck;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      load_s1 <= mcu_load;
      load_s2 <= load_s1;
      load_d  <= load_s2;
    end
  end

  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // The head stays in the FIFO while it is shifted out; only LOAD pops it,
  // so a short read still discards the command.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    load_sh  = 1'b0;
    shift_en = 1'b0;
    mcu_done = 1'b0;
    mcu_sdo  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_count != '0) begin
          load_sh = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        mcu_done = 1'b1;
        mcu_sdo  = shreg[CMD_W-1];
        if (load_rise) begin
          pop     = 1'b1;
          state_d = IDLE;
        end else if (sck_fall) begin
          shift_en = 1'b1;
          if (bcnt == BW'(CMD_W - 1)) state_d = WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        mcu_done = 1'b1;
        if (load_rise) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n)   bcnt <= '0;
    else if (load_sh)  bcnt <= '0;
    else if (shift_en) bcnt <= bcnt + BW'(1);
  end

  always_ff @(posedge clk) begin
    if (load_sh)       shreg <= mem[rd_ptr];
    else if (shift_en) shreg <= shreg << 1;
  end

endmodule

// File: tb/tb_drum_cmd_spi_queue.sv
// Testbench for drum_cmd_spi_queue: directed hit patterns with the MCU side
// modelled by tasks; expected command codes are queued at stimulus time and
// a monitor compares every complete frame the MCU reads.
module tb_drum_cmd_spi_queue;
  localparam int NUM_CH = 8;
  localparam int CMD_W  = 8;
  localparam int DEPTH  = 4;

  logic                   clk = 1'b0;
  logic                   fpga_rst_n = 1'b0;
  logic [NUM_CH-1:0]      trig = '0;
  logic                   mcu_sck = 1'b0;
  logic                   mcu_load = 1'b0;
  logic                   ovf_clr = 1'b0;
  logic                   mcu_sdo;
  logic                   mcu_done;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;

  int n_vec = 0;
  int n_err = 0;
  logic [CMD_W-1:0] exp_q[$];

  drum_cmd_spi_queue #(.NUM_CH(NUM_CH), .CMD_W(CMD_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .fpga_rst_n(fpga_rst_n), .trig(trig), .mcu_sck(mcu_sck),
    .mcu_load(mcu_load), .mcu_sdo(mcu_sdo), .mcu_done(mcu_done),
    .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_trig(input logic [NUM_CH-1:0] m);
    @(negedge clk) trig = m;
    @(negedge clk) trig = '0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!mcu_done && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!mcu_done) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_done: mcu_done still 0 after %0d cycles, expected 1", t);
    end
  endtask

  task automatic sck_bits(input int n);
    repeat (n) begin
      @(negedge clk) mcu_sck = 1'b1;
      wait_clks(4);
      mcu_sck = 1'b0;
      wait_clks(3);
    end
  endtask

  task automatic read_frame(input int nbits);
    wait_done();
    wait_clks(2);
    sck_bits(nbits);
    wait_clks(3);
    mcu_load = 1'b1;
    wait_clks(4);
    mcu_load = 1'b0;
    wait_clks(2);
  endtask

  // Monitor: plays the MCU receiver, sampling sdo on sck rising edges and
  // scoring each full-length frame at its LOAD edge.
  initial begin : monitor
    logic [CMD_W-1:0] rx;
    logic [CMD_W-1:0] e;
    int nb;
    rx = '0;
    nb = 0;
    forever begin
      @(posedge mcu_sck or posedge mcu_load or negedge fpga_rst_n);
      if (!fpga_rst_n) begin
        nb = 0;
        rx = '0;
      end else if (mcu_load) begin
        if (nb == CMD_W) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL frame: got 0x%02h, expected no frame", rx);
          end else begin
            e = exp_q.pop_front();
            check("frame", int'(rx), int'(e));
          end
        end
        nb = 0;
        rx = '0;
      end else if (mcu_done) begin
        rx = {rx[CMD_W-2:0], mcu_sdo};
        nb++;
      end
    end
  end

  initial begin : stim
    int seen;
    wait_clks(3);
    check("rst_done", mcu_done, 0);
    check("rst_sdo", mcu_sdo, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk) fpga_rst_n = 1'b1;
    wait_clks(2);

    // Single hit on channel 1: latency and full frame.
    exp_q.push_back(8'h02);
    pulse_trig(8'b0000_0010);
    @(posedge clk) #1;
    check("lat_k1_done", mcu_done, 0);
    check("lat_k1_count", fifo_count, 1);
    @(posedge clk) #1;
    check("lat_k2_done", mcu_done, 1);
    read_frame(8);
    wait_clks(2);
    check("single_done_low", mcu_done, 0);
    check("single_count", fifo_count, 0);

    // Back-to-back trig on one channel: second lands on the clearing cycle.
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h01);
    @(negedge clk) trig = 8'b0000_0001;
    @(negedge clk) trig = 8'b0000_0001;
    @(negedge clk) trig = '0;
    wait_clks(2);
    check("setwins_ovf", overflow, 0);
    check("setwins_count", fifo_count, 2);
    read_frame(8);
    read_frame(8);

    // Simultaneous hits arbitrate lowest channel first.
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h08);
    pulse_trig(8'b1000_0101);
    read_frame(8);
    read_frame(8);
    read_frame(8);
    wait_clks(4);
    check("simul_count", fifo_count, 0);

    // Full FIFO, pending channel 2, then a merge.
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h03);
    pulse_trig(8'b0001_1011);
    wait_clks(6);
    check("full_count", fifo_count, 4);
    pulse_trig(8'b0000_0100);
    wait_clks(2);
    check("pend_no_ovf", overflow, 0);
    pulse_trig(8'b0000_0100);
    check("merge_ovf", overflow, 1);
    check("merge_count", fifo_count, 4);
    read_frame(8);
    check("full_pop_push_count", fifo_count, 4);
    repeat (4) read_frame(8);
    wait_clks(6);
    check("merge_drained", fifo_count, 0);
    check("merge_done_low", mcu_done, 0);
    check("ovf_sticky", overflow, 1);
    @(negedge clk) ovf_clr = 1'b1;
    @(negedge clk) ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);

    // Short read discards the command; the next frame starts at its MSB.
    exp_q.push_back(8'h07);
    pulse_trig(8'b0110_0000);
    wait_clks(4);
    read_frame(3);
    check("short_count", fifo_count, 1);
    read_frame(8);
    wait_clks(4);
    check("short_drained", fifo_count, 0);

    // Wrap-around stress: 3*DEPTH single hits, concurrent random reads.
    fork
      begin : issuer
        int ch;
        int t;
        for (int i = 0; i < 3 * DEPTH; i++) begin
          ch = int'($urandom_range(NUM_CH - 1, 0));
          t = 0;
          while (fifo_count >= DEPTH && t < 500) begin
            @(negedge clk);
            t++;
          end
          if (t >= 500) begin
            n_vec++;
            n_err++;
            $display("FAIL stress_space: fifo_count %0d, expected below %0d", fifo_count, DEPTH);
          end
          exp_q.push_back(CMD_W'(ch + 1));
          pulse_trig(NUM_CH'(1) << ch);
          wait_clks(1 + int'($urandom_range(3, 0)));
        end
      end
      begin : reader
        for (int j = 0; j < 3 * DEPTH; j++) begin
          wait_clks(int'($urandom_range(10, 0)));
          read_frame(8);
        end
      end
    join
    wait_clks(4);
    check("stress_ovf", overflow, 0);
    check("stress_count", fifo_count, 0);

    // Reset in the middle of a frame with three entries queued.
    pulse_trig(8'b0000_0111);
    wait_clks(6);
    check("pre_rst_count", fifo_count, 3);
    wait_done();
    wait_clks(2);
    sck_bits(3);
    @(negedge clk) fpga_rst_n = 1'b0;
    #1;
    check("midrst_done", mcu_done, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_sdo", mcu_sdo, 0);
    wait_clks(3);
    fpga_rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (mcu_done) seen = 1;
    end
    check("no_stale_frame", seen, 0);
    check("post_rst_count", fifo_count, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
